// File: rtl/clock_generation.sv
// rtl/clock_generation.sv - programmable recovery clock generator (single, differential, quadrature)
//
// Purpose: produces a primary pin clock of period 2*H system clocks, plus a
// secondary pin that is held low, complementary or lagging by a quarter
// period. It can be drained cleanly to a stop or paused on request.
//
// Ports:
//   sys_dom_i          clock and synchronous active-high reset
//   generation_en_i    run request
//   generation_mode_i  SINGLE/DIF/QUAD, continuous or pausable
//   half_period_i      system clocks per primary half-phase
//   pause_req_i        pause request, pausable modes only
//   io_clk_o           primary/secondary pins
//   rising_edge_o      primary 0->1 strobe
//   falling_edge_o     primary 1->0 strobe
//   any_edge_o         any pin transition strobe
//   running_o          generator active (run or drain)
//   paused_o           generator held in pause

package common_p;
  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  typedef enum logic [2:0] {
    SINGLE_CONTINUOUS = 3'd0,
    SINGLE_PAUSABLE   = 3'd1,
    DIF_CONTINUOUS    = 3'd2,
    DIF_PAUSABLE      = 3'd3,
    QUAD_CONTINUOUS   = 3'd4,
    QUAD_PAUSABLE     = 3'd5
  } mode_e;

  typedef struct packed {
    logic primary;
    logic secondary;
  } recovery_pins_s;

  function automatic logic is_quad(mode_e m);
    return (m == QUAD_CONTINUOUS) || (m == QUAD_PAUSABLE);
  endfunction

  function automatic logic is_dif(mode_e m);
    return (m == DIF_CONTINUOUS) || (m == DIF_PAUSABLE);
  endfunction

  function automatic logic is_pausable(mode_e m);
    return (m == SINGLE_PAUSABLE) || (m == DIF_PAUSABLE) || (m == QUAD_PAUSABLE);
  endfunction
endpackage

module clock_generation #(
  parameter int COUNT_W = 16
) (
  input  common_p::clk_dom_s          sys_dom_i,
  input  logic                        generation_en_i,
  input  clks_alot_p::mode_e          generation_mode_i,
  input  logic [COUNT_W-1:0]          half_period_i,
  input  logic                        pause_req_i,
  output clks_alot_p::recovery_pins_s io_clk_o,
  output logic                        rising_edge_o,
  output logic                        falling_edge_o,
  output logic                        any_edge_o,
  output logic                        running_o,
  output logic                        paused_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_PAUSED} state_e;

  state_e             state_q, state_d;
  clks_alot_p::mode_e mode_q, mode_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] half_q, half_d;
  logic [COUNT_W-1:0] quarter_q, quarter_d;
  logic [COUNT_W-1:0] lat_half;
  logic               pause_mark_q, pause_mark_d;
  logic               prim_q, prim_d, sec_q, sec_d;
  logic               rise_q, rise_d, fall_q, fall_d, any_q, any_d;
  logic               running_q, running_d, paused_q, paused_d;
  logic               start, advance, prim_tog, sec_tog;
  logic               at_end, at_quarter;

  assign at_end     = (cnt_q == half_q - COUNT_W'(1));
  assign at_quarter = (cnt_q == quarter_q - COUNT_W'(1));

  always_ff @(posedge sys_dom_i.clk) begin
    if (sys_dom_i.sync_rst) begin
      state_q      <= S_IDLE;
      mode_q       <= clks_alot_p::SINGLE_CONTINUOUS;
      cnt_q        <= '0;
      half_q       <= '0;
      quarter_q    <= '0;
      pause_mark_q <= 1'b0;
      prim_q       <= 1'b0;
      sec_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      any_q        <= 1'b0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      quarter_q    <= quarter_d;
      pause_mark_q <= pause_mark_d;
      prim_q       <= prim_d;
      sec_q        <= sec_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      any_q        <= any_d;
      running_q    <= running_d;
      paused_q     <= paused_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    quarter_d    = quarter_q;
    pause_mark_d = pause_mark_q;
    prim_d       = prim_q;
    sec_d        = sec_q;
    start        = 1'b0;
    advance      = 1'b0;
    prim_tog     = 1'b0;
    sec_tog      = 1'b0;

    // Quadrature needs at least two cycles per half-phase to place the
    // secondary edge strictly inside it; other modes only avoid H=0.
    lat_half = half_period_i;
    if (clks_alot_p::is_quad(generation_mode_i)) begin
      if (half_period_i < COUNT_W'(2)) lat_half = COUNT_W'(2);
    end else if (half_period_i == '0) begin
      lat_half = COUNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (generation_en_i) begin
          mode_d       = generation_mode_i;
          half_d       = lat_half;
          quarter_d    = lat_half >> 1;
          pause_mark_d = 1'b0;
          start        = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        advance = 1'b1;
        if (!generation_en_i) begin
          state_d      = S_DRAIN;
          pause_mark_d = 1'b0;
        end else if (clks_alot_p::is_pausable(mode_q) && pause_req_i) begin
          state_d      = S_DRAIN;
          pause_mark_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // A disable arriving during a pause drain turns it into a full stop.
        if (!generation_en_i) pause_mark_d = 1'b0;
        // Last cycle of a low phase: swallow the rising edge and stop.
        if (!prim_q && at_end) begin
          state_d = pause_mark_d ? S_PAUSED : S_IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      S_PAUSED: begin
        if (!generation_en_i) begin
          state_d = S_IDLE;
        end else if (!pause_req_i) begin
          start   = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      cnt_d    = '0;
      prim_d   = 1'b1;
      sec_d    = 1'b0;
      prim_tog = 1'b1;
    end

    if (advance) begin
      if (at_end) begin
        cnt_d    = '0;
        prim_d   = ~prim_q;
        prim_tog = 1'b1;
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
      if (clks_alot_p::is_quad(mode_q) && at_quarter) begin
        sec_d   = ~sec_q;
        sec_tog = 1'b1;
      end
      if (clks_alot_p::is_dif(mode_q)) sec_d = ~prim_d;
    end

    rise_d    = prim_tog & ~prim_q;
    fall_d    = prim_tog & prim_q;
    any_d     = prim_tog | sec_tog;
    running_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    paused_d  = (state_d == S_PAUSED);
  end

  assign io_clk_o.primary   = prim_q;
  assign io_clk_o.secondary = sec_q;
  assign rising_edge_o      = rise_q;
  assign falling_edge_o     = fall_q;
  assign any_edge_o         = any_q;
  assign running_o          = running_q;
  assign paused_o           = paused_q;

endmodule

// File: tb/tb_clock_generation.sv
// tb/tb_clock_generation.sv - self-checking bench for clock_generation
module tb_clock_generation;
  localparam int COUNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  common_p::clk_dom_s sys_dom;
  logic en, preq;
  clks_alot_p::mode_e mode;
  logic [COUNT_W-1:0] hp;
  clks_alot_p::recovery_pins_s pins;
  logic rise, fall, anye, running, paused;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: position t within a 2H-cycle period, pins derived from t.
  int mst, t, mh, mq;
  clks_alot_p::mode_e mmode;
  bit mpause, mp, ms, mrise, mfall, many, mrun, mpsd;

  bit pat_p[7] = '{1, 1, 1, 0, 0, 0, 1};
  bit pat_r[7] = '{1, 0, 0, 0, 0, 0, 1};
  bit pat_f[7] = '{0, 0, 0, 1, 0, 0, 0};

  assign sys_dom = {clk, rst};
  always #5 clk = ~clk;

  clock_generation #(.COUNT_W(COUNT_W)) dut (
    .sys_dom_i        (sys_dom),
    .generation_en_i  (en),
    .generation_mode_i(mode),
    .half_period_i    (hp),
    .pause_req_i      (preq),
    .io_clk_o         (pins),
    .rising_edge_o    (rise),
    .falling_edge_o   (fall),
    .any_edge_o       (anye),
    .running_o        (running),
    .paused_o         (paused)
  );

  function automatic bit quad(clks_alot_p::mode_e m);
    return (m == clks_alot_p::QUAD_CONTINUOUS) || (m == clks_alot_p::QUAD_PAUSABLE);
  endfunction

  function automatic bit dif(clks_alot_p::mode_e m);
    return (m == clks_alot_p::DIF_CONTINUOUS) || (m == clks_alot_p::DIF_PAUSABLE);
  endfunction

  function automatic bit pausable(clks_alot_p::mode_e m);
    return (m == clks_alot_p::SINGLE_PAUSABLE) || (m == clks_alot_p::DIF_PAUSABLE) ||
           (m == clks_alot_p::QUAD_PAUSABLE);
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit op, os;
    op = mp;
    os = ms;
    if (rst) begin
      mst = 0; t = 0; mp = 0; ms = 0;
    end else begin
      case (mst)
        0: if (en) begin
             mmode = mode;
             mh = (hp == 0) ? 1 : int'(hp);
             if (quad(mmode) && mh < 2) mh = 2;
             mq = mh / 2;
             t = 0; mst = 1; mpause = 0;
           end
        1: begin
             t = (t + 1) % (2 * mh);
             if (!en) begin mst = 2; mpause = 0; end
             else if (pausable(mmode) && preq) begin mst = 2; mpause = 1; end
           end
        2: begin
             if (!en) mpause = 0;
             if (t == 2 * mh - 1) mst = mpause ? 3 : 0;
             else t = t + 1;
           end
        default: begin
             if (!en) mst = 0;
             else if (!preq) begin mst = 1; t = 0; end
           end
      endcase
      if (mst == 1 || mst == 2) begin
        mp = (t < mh);
        if (quad(mmode)) ms = (((t + 2 * mh - mq) % (2 * mh)) < mh);
        else if (dif(mmode)) ms = !mp;
        else ms = 0;
      end
    end
    if (rst) begin
      mrise = 0; mfall = 0; many = 0;
    end else begin
      mrise = !op && mp;
      mfall = op && !mp;
      many  = (op != mp) || (quad(mmode) && (os != ms));
    end
    mrun = (mst == 1 || mst == 2);
    mpsd = (mst == 3);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("primary", pins.primary, mp);
    check("secondary", pins.secondary, ms);
    check("rising_edge", rise, mrise);
    check("falling_edge", fall, mfall);
    check("any_edge", anye, many);
    check("running", running, mrun);
    check("paused", paused, mpsd);
  endtask

  initial begin
    rst = 1; en = 0; preq = 0; mode = clks_alot_p::SINGLE_CONTINUOUS; hp = 3;
    mst = 0; t = 0; mh = 1; mq = 0; mmode = clks_alot_p::SINGLE_CONTINUOUS;
    mpause = 0; mp = 0; ms = 0; mrise = 0; mfall = 0; many = 0; mrun = 0; mpsd = 0;
    repeat (2) cycle();
    rst = 0;

    // Single continuous, H=3: fixed waveform from the enable cycle.
    en = 1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("h3_primary", pins.primary, pat_p[i]);
      check("h3_rise", rise, pat_r[i]);
      check("h3_fall", fall, pat_f[i]);
      check("h3_secondary", pins.secondary, 1'b0);
    end
    en = 0;
    repeat (10) cycle();

    // Differential, H=2, disabled mid-high.
    mode = clks_alot_p::DIF_CONTINUOUS; hp = 2; en = 1;
    repeat (5) cycle();
    en = 0;
    repeat (8) cycle();
    check("dif_idle_primary", pins.primary, 1'b0);
    check("dif_idle_secondary", pins.secondary, 1'b1);

    // Quadrature pausable, H=4, pause then resume.
    mode = clks_alot_p::QUAD_PAUSABLE; hp = 4; en = 1;
    repeat (12) cycle();
    preq = 1;
    repeat (12) cycle();
    check("quad_paused", paused, 1'b1);
    check("quad_paused_primary", pins.primary, 1'b0);
    check("quad_paused_secondary", pins.secondary, 1'b0);
    preq = 0;
    cycle();
    check("quad_resume_primary", pins.primary, 1'b1);
    en = 0;
    repeat (12) cycle();

    // Quadrature with H=1, then single with H=0.
    mode = clks_alot_p::QUAD_CONTINUOUS; hp = 1; en = 1;
    repeat (10) cycle();
    en = 0;
    repeat (10) cycle();
    mode = clks_alot_p::SINGLE_CONTINUOUS; hp = 0; en = 1;
    repeat (6) cycle();
    en = 0;
    repeat (4) cycle();

    // Continuous mode ignores pause; mode/H changes while running are ignored.
    mode = clks_alot_p::SINGLE_CONTINUOUS; hp = 2; preq = 1; en = 1;
    repeat (6) cycle();
    mode = clks_alot_p::QUAD_PAUSABLE; hp = 5;
    repeat (10) cycle();
    check("cont_no_pause", paused, 1'b0);
    en = 0;
    repeat (10) cycle();
    preq = 0;

    // Reset mid-high phase, then restart.
    mode = clks_alot_p::SINGLE_CONTINUOUS; hp = 4; en = 1;
    repeat (2) cycle();
    rst = 1;
    cycle();
    check("rst_primary", pins.primary, 1'b0);
    check("rst_running", running, 1'b0);
    rst = 0;
    cycle();
    check("restart_primary", pins.primary, 1'b1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(24) == 0) preq = ~preq;
      if ($urandom_range(9) == 0) mode = clks_alot_p::mode_e'(3'($urandom_range(5)));
      if ($urandom_range(9) == 0) hp = COUNT_W'($urandom_range(7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_generation.md
CLOCK_GENERATION -- requirements
Module: clock_generation

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the half-period counter and of half_period_i.
REQ-002 SHALL have port sys_dom_i, input, common_p::clk_dom_s, carrying the single clock sys_dom_i.clk and the synchronous active-high reset sys_dom_i.sync_rst; the module has one clock, and reset is synchronous and active-high.
REQ-003 SHALL have port generation_en_i, input, 1: request to run the generator.
REQ-004 SHALL have port generation_mode_i, input, clks_alot_p::mode_e: SINGLE/DIF/QUAD, each _CONTINUOUS or _PAUSABLE.
REQ-005 SHALL have port half_period_i, input, COUNT_W: sys clocks per primary half-phase.
REQ-006 SHALL have port pause_req_i, input, 1: pause request; honoured only in *_PAUSABLE modes.
REQ-007 SHALL have port io_clk_o, output, clks_alot_p::recovery_pins_s: fields primary and secondary.
REQ-008 SHALL have ports rising_edge_o, falling_edge_o and any_edge_o, output, 1 each: strobes aligned to pin transitions.
REQ-009 SHALL have ports running_o and paused_o, output, 1 each: status.

Function
REQ-010 SHALL implement states IDLE, RUN, DRAIN and PAUSED; all outputs SHALL be registered.
REQ-011 IDLE SHALL, when generation_en_i=1 is sampled, latch mode and half_period (H) and go to RUN; primary SHALL rise in the next cycle (latency 1).
REQ-012 H=0 SHALL be treated as 1; in QUAD modes H<2 SHALL be treated as 2 and odd H SHALL be used unchanged, with the quarter point at floor(H/2).
REQ-013 RUN SHALL keep a phase counter c=0..H-1, reset to 0 on each primary toggle; primary SHALL toggle when c=H-1, giving period 2H and 50% duty.
REQ-014 SINGLE modes SHALL hold secondary at 0.
REQ-015 DIF modes SHALL drive secondary = ~primary in the same cycle.
REQ-016 QUAD modes SHALL toggle secondary when c=floor(H/2)-1, so that secondary lags primary by H/2 cycles.
REQ-017 rising_edge_o and falling_edge_o SHALL pulse for one cycle when primary goes 0->1 and 1->0 respectively.
REQ-018 any_edge_o SHALL pulse on any primary toggle; in QUAD modes it SHALL also pulse on any secondary toggle; a simultaneous toggle SHALL give a single pulse.
REQ-019 In RUN, generation_en_i=0 SHALL move the block to DRAIN.
REQ-020 In RUN in a *_PAUSABLE mode, pause_req_i=1 SHALL move the block to DRAIN, marked as a pause.
REQ-021 DRAIN SHALL continue toggling until the end of the current primary low phase and SHALL suppress the next rising edge; it SHALL then go to IDLE (disable) or PAUSED (pause).
REQ-022 If a primary high phase is in progress on entry to DRAIN, DRAIN SHALL complete that high phase and the following low phase.
REQ-023 If disable and pause are requested together, disable SHALL win.
REQ-024 On leaving DRAIN, the pins SHALL hold their values: primary=0; secondary=1 in DIF modes and 0 otherwise.
REQ-025 In DRAIN, a QUAD secondary fall SHALL be completed before the block stops.
REQ-026 PAUSED SHALL assert paused_o and hold the pins.
REQ-027 In PAUSED, pause_req_i=0 with generation_en_i=1 SHALL move the block to RUN, with primary rising in the next cycle and c=0; generation_en_i=0 SHALL move the block to IDLE.
REQ-028 Continuous modes SHALL ignore pause_req_i entirely.
REQ-029 Changes on generation_mode_i and half_period_i outside IDLE and PAUSED SHALL be ignored; PAUSED->RUN SHALL NOT relatch.
REQ-030 running_o SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-031 In IDLE, secondary SHALL retain its last value.

Reset
REQ-032 When sys_dom_i.sync_rst=1 is sampled, state SHALL become IDLE and c SHALL become 0.
REQ-033 Reset SHALL force primary=0, secondary=0 and all strobes and status outputs to 0 in the next cycle.
REQ-034 Reset mid-run SHALL abort immediately, without a drain.

Verification
REQ-035 SINGLE_CONTINUOUS, H=3, en at cycle 0 -> primary high at cycles 1-3 and low at 4-6; rising_edge_o at 1,7; falling_edge_o at 4; secondary=0 throughout.
REQ-036 DIF_CONTINUOUS, H=2 -> secondary = ~primary every cycle; after en deasserts mid-high, the current period completes and the block idles with primary=0, secondary=1 and no extra edges.
REQ-037 QUAD_PAUSABLE, H=4 -> secondary rises 2 cycles after each primary rise; any_edge_o pulses every 2 cycles; pause_req -> stops with both pins 0 and paused_o=1; release -> primary rises in the next cycle.
REQ-038 QUAD, H=1 -> behaves as H=2; SINGLE, H=0 -> primary toggles every cycle.
REQ-039 SINGLE_CONTINUOUS with pause_req_i=1 held -> no pause and paused_o stays 0; a mode or H change while running has no effect until the block returns to IDLE.
REQ-040 sync_rst asserted mid-high phase -> next cycle all outputs 0 and state IDLE; en then restarts with latency 1.
